disp_tick_counter: RTL and testbench
====================================

Name: disp_tick_counter

Overview:
Parametrised display-value counter for the 6-digit seven-segment driver.
- Internal prescaler generates one of two selectable tick rates.
- Counter steps between programmable bounds, up or down, with run/pause, synchronous load and a wrap flag.
- Outputs `data`/`point`/`en`/`sign` connect directly to the segment display driver.

Parameters:
CLK_FREQ, 50_000_000, system clock frequency in Hz
TICK_FAST_MS, 100, tick period in ms when sw=0
TICK_SLOW_MS, 1000, tick period in ms when sw=1
DATA_W, 20, width of displayed value (max 20)
CNT_MIN, 0, lower count bound (inclusive)
CNT_MAX, 7, upper count bound (inclusive); must satisfy CNT_MIN < CNT_MAX < 2^DATA_W
POINT_POS, 6'b000000, decimal-point mask driven after reset

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
sw  input  1  rate select: 0 = fast tick, 1 = slow tick
run  input  1  1 = prescaler advances; 0 = pause (prescaler and data hold)
dir  input  1  0 = count up, 1 = count down
load  input  1  synchronous load strobe
load_val  input  DATA_W  value to load
data  output  DATA_W  displayed value (register)
point  output  6  decimal-point mask (register)
en  output  1  display enable (register)
sign  output  1  minus-sign enable (register)
wrap  output  1  one-cycle pulse on bound crossing (register)

Behaviour:
- Clock `clk`, single domain; reset `rst_n` asynchronous, active-low.
- Reset values: `data`=CNT_MIN, `point`=0, `en`=0, `sign`=0, `wrap`=0, prescaler=0, `sw_q`=0.
- First clock after reset release: `en`=1, `point`=POINT_POS, `sign`=0. These hold until the next reset.
- Divisors:
  - DIV_F = CLK_FREQ/1000*TICK_FAST_MS
  - DIV_S = CLK_FREQ/1000*TICK_SLOW_MS
  - Prescaler width = clog2(max(DIV_F, DIV_S)).
- Prescaler:
  - When run=1: counts 0..DIV-1, then returns to 0. DIV is selected by the current `sw`.
  - When run=0: holds.
  - `sw_q` registers `sw`. If sw != sw_q, the prescaler is forced to 0 that cycle and no tick is generated.
- Tick: asserted combinationally when run=1, prescaler==DIV-1 and sw==sw_q.
- Data update happens on the same edge the prescaler returns to 0. Latency from the terminal count to new `data` is 0 cycles.
- Priority per cycle: load > tick > hold.
- Load:
  - `data` <= load_val, clamped to [CNT_MIN, CNT_MAX].
  - Prescaler <= 0.
  - No `wrap`. Any tick in the same cycle is discarded.
- Tick with dir=0 (up):
  - data < CNT_MAX: data+1.
  - data >= CNT_MAX: data <= CNT_MIN, wrap <= 1.
- Tick with dir=1 (down):
  - data > CNT_MIN: data-1.
  - data <= CNT_MIN: data <= CNT_MAX, wrap <= 1.
- `wrap`: high for exactly one cycle, coincident with the wrapped `data`. Otherwise 0.
- `dir` may change at any time; it takes effect on the next tick. No prescaler reset.
- Pause (run=0) mid-period: the prescaler value is retained, and the period resumes from that value.
- Reset mid-operation: all state returns to reset values immediately.

Optional Feature:
Macro: DISP_BOUNCE_EN
- Defined:
  - Bounds reflect instead of wrapping. An internal direction bit `dir_i` (reset 0) is used in place of `dir` for counting.
  - Up tick at CNT_MAX: data <= CNT_MAX-1, dir_i <= 1, wrap pulse.
  - Down tick at CNT_MIN: data <= CNT_MIN+1, dir_i <= 0, wrap pulse.
  - `dir` input loads `dir_i` only on a `load` strobe.
  - `sign` mirrors `dir_i` (minus shown while descending).
- Not defined: wrap behaviour as above; `sign` constant 0; `dir` used directly.

Test Plan:
Bench parameters: CLK_FREQ=10_000, TICK_FAST_MS=1 (DIV_F=10), TICK_SLOW_MS=5 (DIV_S=50), CNT_MIN=2, CNT_MAX=5.
1. Reset, run=1, sw=0, dir=0 -> `en`=1 one cycle after release; `data` 2→3→4→5→2 every 10 clocks; `wrap` pulses once with `data`=2.
2. dir=1, data=2, tick -> `data`=5 with `wrap`=1; next tick `data`=4, `wrap`=0.
3. sw toggled 0→1 at prescaler=7 -> no tick in that window; next `data` step exactly 51 clocks after toggle, then every 50.
4. load=1, load_val=9, coincident with tick -> `data`=5, no `wrap`, next tick 10 clocks later; load_val=0 -> `data`=2.
5. run=0 at prescaler=4 for 100 clocks -> `data` holds; after run=1, step occurs 6 clocks later.
6. DISP_BOUNCE_EN, dir=0 from 2 -> `data` 2,3,4,5,4,3,2,3; `wrap` at 5 and 2; `sign`=1 while descending; `rst_n` low mid-count -> `data`=2 and `sign`=0 immediately.

Source files
------------

// File: rtl/disp_tick_counter.sv
// disp_tick_counter: prescaled bounded up/down counter feeding the 6-digit seven-segment driver.
// Define DISP_BOUNCE_EN to reflect at the bounds instead of wrapping.
module disp_tick_counter #(
  parameter int         CLK_FREQ     = 50_000_000,
  parameter int         TICK_FAST_MS = 100,
  parameter int         TICK_SLOW_MS = 1000,
  parameter int         DATA_W       = 20,
  parameter int         CNT_MIN      = 0,
  parameter int         CNT_MAX      = 7,
  parameter logic [5:0] POINT_POS    = 6'b000000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              sw,
  input  logic              run,
  input  logic              dir,
  input  logic              load,
  input  logic [DATA_W-1:0] load_val,
  output logic [DATA_W-1:0] data,
  output logic [5:0]        point,
  output logic              en,
  output logic              sign,
  output logic              wrap
);
  localparam int DIV_F = CLK_FREQ / 1000 * TICK_FAST_MS;
  localparam int DIV_S = CLK_FREQ / 1000 * TICK_SLOW_MS;
  localparam int DIV_M = DIV_F > DIV_S ? DIV_F : DIV_S;
  localparam int PW    = DIV_M > 1 ? $clog2(DIV_M) : 1;
  localparam logic [PW-1:0]     TERM_F = PW'(DIV_F - 1);
  localparam logic [PW-1:0]     TERM_S = PW'(DIV_S - 1);
  localparam logic [DATA_W-1:0] MIN_V  = DATA_W'(CNT_MIN);
  localparam logic [DATA_W-1:0] MAX_V  = DATA_W'(CNT_MAX);
  logic [PW-1:0]     pre;
  logic              sw_q;
  logic              tick;
  logic              dir_c;
  logic              wrap_nx;
  logic [DATA_W-1:0] load_c;
  logic [DATA_W-1:0] data_nx;
`ifdef DISP_BOUNCE_EN
  localparam bit BOUNCE = 1'b1;
  logic dir_i;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) dir_i <= 1'b0;
    else        dir_i <= load ? dir : dir_i ^ wrap_nx;
  assign dir_c = dir_i;
  assign sign  = dir_i;
`else
  localparam bit BOUNCE = 1'b0;
  assign dir_c = dir;
  assign sign  = 1'b0;
`endif
  // a rate change restarts the period, so no tick fires until sw has settled for a cycle
  assign tick   = run && sw == sw_q && pre == (sw ? TERM_S : TERM_F);
  assign load_c = $signed({1'b0, load_val}) < $signed({1'b0, MIN_V}) ? MIN_V :
                  load_val > MAX_V ? MAX_V : load_val;
  always_comb begin
    data_nx = data;
    wrap_nx = 1'b0;
    if (load) data_nx = load_c;
    else if (tick) begin
      wrap_nx = dir_c ? !(data > MIN_V) : data >= MAX_V;
      data_nx = dir_c ? (wrap_nx ? (BOUNCE ? MIN_V + 1'b1 : MAX_V) : data - 1'b1)
                      : (wrap_nx ? (BOUNCE ? MAX_V - 1'b1 : MIN_V) : data + 1'b1);
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data  <= MIN_V;
      point <= '0;
      en    <= 1'b0;
      wrap  <= 1'b0;
      pre   <= '0;
      sw_q  <= 1'b0;
    end else begin
      data  <= data_nx;
      point <= POINT_POS;
      en    <= 1'b1;
      wrap  <= wrap_nx;
      sw_q  <= sw;
      pre   <= (load || sw != sw_q || tick) ? '0 : run ? pre + 1'b1 : pre;
    end
  end
endmodule

// File: tb/tb_disp_tick_counter.sv
// tb_disp_tick_counter: scoreboard bench; expected data steps are queued with their cycle and matched on each DUT change.
module tb_disp_tick_counter;
  localparam int         DW = 20;
  localparam logic [5:0] PP = 6'b001010;
  logic          clk = 1'b0, rst_n = 1'b1, sw = 1'b0, run = 1'b0, dir = 1'b0, load = 1'b0;
  logic [DW-1:0] load_val = '0;
  logic [DW-1:0] data, prev;
  logic [5:0]    point;
  logic          en, sign, wrap;
  int            cyc = 0, n_vec = 0, n_err = 0;
  typedef struct {string tag; int d; bit w; bit s; int c;} exp_t;
  exp_t q[$];
  exp_t e;

  disp_tick_counter #(
    .CLK_FREQ(10_000), .TICK_FAST_MS(1), .TICK_SLOW_MS(5),
    .DATA_W(DW), .CNT_MIN(2), .CNT_MAX(5), .POINT_POS(PP)
  ) dut (
    .clk(clk), .rst_n(rst_n), .sw(sw), .run(run), .dir(dir), .load(load),
    .load_val(load_val), .data(data), .point(point), .en(en), .sign(sign), .wrap(wrap)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic push(input string tag, input int d, input bit w, input bit s, input int c);
    q.push_back('{tag, d, w, s, c});
  endtask

  task automatic wait_cyc(input int n);
    while (cyc < n) @(negedge clk);
  endtask

  task automatic do_reset(output int r);
    check("pending", 32'(q.size()), 0);
    @(negedge clk);
    rst_n = 1'b0; run = 1'b0; sw = 1'b0; dir = 1'b0; load = 1'b0; load_val = '0;
    @(negedge clk);
    check("rst.data", 32'(data), 2);
    check("rst.en", 32'(en), 0);
    check("rst.point", 32'(point), 0);
    check("rst.wrap", 32'(wrap), 0);
    check("rst.sign", 32'(sign), 0);
    rst_n = 1'b1;
    r = cyc;
  endtask

  // every data change or wrap pulse must match the head of the queue, including its cycle
  always @(posedge clk) begin
    #1;
    if (rst_n && (data !== prev || wrap !== 1'b0)) begin
      if (q.size() == 0) check("spurious", {11'b0, wrap, data}, {12'b0, prev});
      else begin
        e = q.pop_front();
        check({e.tag, ".data"}, 32'(data), 32'(e.d));
        check({e.tag, ".wrap"}, 32'(wrap), 32'(e.w));
        check({e.tag, ".sign"}, 32'(sign), 32'(e.s));
        check({e.tag, ".cyc"}, 32'(cyc), 32'(e.c));
      end
    end
    prev = data;
  end

  initial begin
    int r;
    #1 rst_n = 1'b0;
    do_reset(r);
    run = 1'b1;
    check("en.pre", 32'(en), 0);
    @(negedge clk);
    check("en.post", 32'(en), 1);
    check("point.post", 32'(point), 32'(PP));
    check("sign.post", 32'(sign), 0);
`ifndef DISP_BOUNCE_EN
    push("t1a", 3, 0, 0, r + 10);
    push("t1b", 4, 0, 0, r + 20);
    push("t1c", 5, 0, 0, r + 30);
    push("t1w", 2, 1, 0, r + 40);
    wait_cyc(r + 41);
    dir = 1'b1;
    push("t2w", 5, 1, 0, r + 50);
    push("t2n", 4, 0, 0, r + 60);
    push("t4a", 3, 0, 0, r + 70);
    wait_cyc(r + 79);
    load = 1'b1; load_val = 9;
    push("t4ld", 5, 0, 0, r + 80);
    wait_cyc(r + 80);
    load = 1'b0;
    wait_cyc(r + 84);
    load = 1'b1; load_val = 0;
    push("t4lo", 2, 0, 0, r + 85);
    wait_cyc(r + 85);
    load = 1'b0;
    push("t4nx", 5, 1, 0, r + 95);
    wait_cyc(r + 100);
`else
    push("t6a", 3, 0, 0, r + 10);
    push("t6b", 4, 0, 0, r + 20);
    push("t6c", 5, 0, 0, r + 30);
    push("t6top", 4, 1, 1, r + 40);
    push("t6d", 3, 0, 1, r + 50);
    push("t6e", 2, 0, 1, r + 60);
    push("t6bot", 3, 1, 0, r + 70);
    wait_cyc(r + 72);
    dir = 1'b1; load = 1'b1; load_val = 4;
    push("t6ld", 4, 0, 1, r + 73);
    wait_cyc(r + 73);
    load = 1'b0; dir = 1'b0;
    wait_cyc(r + 76);
    check("pending", 32'(q.size()), 0);
    rst_n = 1'b0;
    #1;
    check("t6rst.data", 32'(data), 2);
    check("t6rst.sign", 32'(sign), 0);
    check("t6rst.en", 32'(en), 0);
`endif
    do_reset(r);
    run = 1'b1;
    wait_cyc(r + 7);
    sw = 1'b1;
    push("t3a", 3, 0, 0, r + 58);
    push("t3b", 4, 0, 0, r + 108);
    wait_cyc(r + 110);
    do_reset(r);
    run = 1'b1;
    wait_cyc(r + 4);
    run = 1'b0;
    wait_cyc(r + 104);
    run = 1'b1;
    push("t5", 3, 0, 0, r + 110);
    wait_cyc(r + 112);
    check("pending", 32'(q.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
